// File: rtl/joint_stepdir_in.sv
// Step/direction input decoder for one joint: synchronizes and filters STP/DIR,
// accumulates position, measures the step period and tracks motion.

module joint_stepdir_filt #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);
  logic [1:0] sync;
  logic [3:0] run_cnt;

  // level moves only after FILTER_LEN consecutive samples disagree with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      run_cnt <= '0;
      level   <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (sync[1] == level) begin
        run_cnt <= '0;
      end else if (run_cnt == 4'(FILTER_LEN - 1)) begin
        level   <= sync[1];
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 4'd1;
      end
    end
  end
endmodule

module joint_stepdir_in #(
  parameter int          FILTER_LEN = 4,
  parameter logic [31:0] TIMEOUT    = 32'd5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               jointEnable,
  input  logic               STP,
  input  logic               DIR,
  output logic signed [31:0] jointFeedback,
  output logic        [31:0] jointPeriod,
  output logic               jointDir,
  output logic               jointMoving,
  output logic               stepEvent
);
  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_t;

  state_t      state, state_n;
  logic [1:0]  raw, filt;
  logic        stp_d, primed, step, timeout_hit;
  logic [31:0] cnt, period_n;
  logic [FILTER_LEN+1:0] vld_pipe;

  assign raw = {DIR, STP};

  for (genvar g = 0; g < 2; g++) begin : g_lane
    joint_stepdir_filt #(.FILTER_LEN(FILTER_LEN)) u_filt (
      .clk   (clk),
      .reset (reset),
      .raw   (raw[g]),
      .level (filt[g])
    );
  end

  // A STP held high through reset has reached the filtered level by the time
  // vld_pipe fills, so primed only arms once a genuine low has been seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      primed   <= 1'b0;
      stp_d    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[FILTER_LEN:0], 1'b1};
      primed   <= primed | (vld_pipe[FILTER_LEN+1] & ~filt[0]);
      stp_d    <= filt[0];
    end
  end

  assign step        = jointEnable & primed & filt[0] & ~stp_d;
  assign timeout_hit = (cnt >= TIMEOUT - 32'd1);
  assign jointMoving = (state == RUN);

  always_comb begin
    state_n  = state;
    period_n = jointPeriod;
    if (!jointEnable) begin
      state_n  = IDLE;
      period_n = '0;
    end else if (step) begin
      state_n  = (state == IDLE) ? ARMED : RUN;
      period_n = (state == IDLE) ? 32'd0 : cnt + 32'd1;
    end else if (timeout_hit) begin
      state_n  = IDLE;
      period_n = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      jointPeriod   <= '0;
      jointFeedback <= '0;
      jointDir      <= 1'b0;
      stepEvent     <= 1'b0;
    end else begin
      state       <= state_n;
      jointPeriod <= period_n;
      stepEvent   <= step;
      if (step) cnt <= '0;
      else if (cnt < TIMEOUT) cnt <= cnt + 32'd1;
      if (step) begin
        jointFeedback <= filt[1] ? jointFeedback + 32'sd1 : jointFeedback - 32'sd1;
        jointDir      <= filt[1];
      end
    end
  end
endmodule

// File: tb/tb_joint_stepdir_in.sv
// Scoreboard bench for joint_stepdir_in: stimulus pushes expected steps from a
// rise-time model; a negedge monitor pops and compares on every stepEvent.

module tb_joint_stepdir_in;
  localparam int FL  = 4;
  localparam int TO  = 1000;
  localparam int LAT = FL + 3;

  logic        clk = 1'b0;
  logic        reset, jointEnable, STP, DIR;
  logic [31:0] jointFeedback, jointPeriod;
  logic        jointDir, jointMoving, stepEvent;

  joint_stepdir_in #(.FILTER_LEN(FL), .TIMEOUT(32'(TO))) dut (
    .clk           (clk),
    .reset         (reset),
    .jointEnable   (jointEnable),
    .STP           (STP),
    .DIR           (DIR),
    .jointFeedback (jointFeedback),
    .jointPeriod   (jointPeriod),
    .jointDir      (jointDir),
    .jointMoving   (jointMoving),
    .stepEvent     (stepEvent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          rise;
    logic [31:0] pos;
    logic [31:0] period;
    logic        moving;
    logic        dir;
  } exp_t;

  exp_t q[$];
  int errors = 0, checks = 0;

  // Reference: position count, and the number of steps in the current run,
  // where a run continues while rise-to-rise gaps stay within TO clocks.
  logic [31:0] m_pos;
  int          m_run;
  int          m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_step(input logic d, input int r);
    exp_t e;
    m_pos = d ? m_pos + 32'd1 : m_pos - 32'd1;
    if (m_run > 0 && (r - m_last) <= TO) begin
      m_run++;
      e.period = 32'(r - m_last);
    end else begin
      m_run    = 1;
      e.period = 0;
    end
    e.moving = (m_run >= 2);
    e.dir    = d;
    e.pos    = m_pos;
    e.rise   = r;
    m_last   = r;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (stepEvent === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_step: stepEvent=1 at cycle %0d, required 0", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(cyc - e.rise), 32'(LAT));
        chk("feedback", jointFeedback, e.pos);
        chk("period", jointPeriod, e.period);
        chk("moving", {31'd0, jointMoving}, {31'd0, e.moving});
        chk("dir", {31'd0, jointDir}, {31'd0, e.dir});
      end
    end
  end

  // low: clocks DIR is held before the rise; high: clocks STP stays high
  task automatic pulse(input logic d, input int low, input int high, input bit accept);
    @(posedge clk) #1;
    DIR = d;
    repeat (low) @(posedge clk);
    #1 STP = 1'b1;
    if (accept) model_step(d, cyc);
    repeat (high) @(posedge clk);
    #1 STP = 1'b0;
  endtask

  task automatic at_neg(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int lr;
    reset = 1'b1; jointEnable = 1'b1; STP = 1'b0; DIR = 1'b0;
    m_pos = 0; m_run = 0; m_last = 0;
    idle(3);
    #1;
    chk("rst_feedback", jointFeedback, 0);
    chk("rst_period", jointPeriod, 0);
    chk("rst_dir", {31'd0, jointDir}, 0);
    chk("rst_moving", {31'd0, jointMoving}, 0);
    chk("rst_step", {31'd0, stepEvent}, 0);
    reset = 1'b0;
    idle(20);

    // single step from idle
    pulse(1'b1, 10, 10, 1'b1);
    idle(TO + 20);

    // DIR=0 train every 100 clocks, then let it time out
    for (int i = 0; i < 5; i++) pulse(1'b0, 89, 10, 1'b1);
    lr = m_last;
    at_neg(lr + LAT + TO - 1);
    chk("to_moving_before", {31'd0, jointMoving}, 1);
    chk("to_period_before", jointPeriod, 100);
    at_neg(lr + LAT + TO);
    chk("to_moving_after", {31'd0, jointMoving}, 0);
    chk("to_period_after", jointPeriod, 0);
    chk("to_feedback_hold", jointFeedback, m_pos);
    chk("to_dir_hold", {31'd0, jointDir}, 0);

    // rise gaps of exactly TO (step wins) and TO+1 (already idle)
    pulse(1'b1, 20, 10, 1'b1);
    pulse(1'b1, TO - 11, 10, 1'b1);
    pulse(1'b0, TO - 10, 10, 1'b1);
    pulse(1'b1, 20, 10, 1'b1);

    // glitches shorter than the filter
    for (int i = 0; i < 6; i++) pulse(1'($urandom_range(0, 1)), 8, $urandom_range(1, FL - 1), 1'b0);
    idle(20);
    chk("glitch_feedback", jointFeedback, m_pos);

    // randomized traffic with reversals, glitches and occasional long gaps
    for (int i = 0; i < 40; i++) begin
      int low;
      low = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 20, TO + 20) : $urandom_range(8, 150);
      if ($urandom_range(0, 4) == 0) pulse(1'($urandom_range(0, 1)), 8, $urandom_range(1, FL - 1), 1'b0);
      pulse(1'($urandom_range(0, 1)), low, $urandom_range(FL, 40), 1'b1);
    end
    idle(TO + 20);

    // two's complement wrap in both directions
    force dut.jointFeedback = 32'h7FFF_FFFF;
    @(posedge clk) #1;
    release dut.jointFeedback;
    m_pos = 32'h7FFF_FFFF;
    idle(2);
    chk("preload", jointFeedback, 32'h7FFF_FFFF);
    pulse(1'b1, 20, 10, 1'b1);
    pulse(1'b0, 20, 10, 1'b1);
    idle(20);

    // disable mid-train
    pulse(1'b0, 20, 10, 1'b1);
    pulse(1'b0, 40, 10, 1'b1);
    idle(20);
    chk("en_moving_before", {31'd0, jointMoving}, 1);
    @(posedge clk) #1 jointEnable = 1'b0;
    m_run = 0;
    idle(2);
    #1;
    chk("dis_moving", {31'd0, jointMoving}, 0);
    chk("dis_period", jointPeriod, 0);
    chk("dis_feedback", jointFeedback, m_pos);
    for (int i = 0; i < 3; i++) pulse(1'b1, 20, 10, 1'b0);
    @(posedge clk) #1 STP = 1'b1;
    idle(20);
    #1 jointEnable = 1'b1;
    idle(20);
    #1 STP = 1'b0;
    chk("reen_feedback", jointFeedback, m_pos);
    pulse(1'b1, 20, 10, 1'b1);
    idle(20);

    // reset in the middle of a pulse, STP held high through release
    @(posedge clk) #1 STP = 1'b1;
    idle(3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_feedback", jointFeedback, 0);
    chk("mid_rst_period", jointPeriod, 0);
    chk("mid_rst_dir", {31'd0, jointDir}, 0);
    chk("mid_rst_moving", {31'd0, jointMoving}, 0);
    chk("mid_rst_step", {31'd0, stepEvent}, 0);
    m_pos = 0; m_run = 0;
    idle(2);
    #1 reset = 1'b0;
    idle(30);
    #1 STP = 1'b0;
    chk("held_feedback", jointFeedback, 0);
    pulse(1'b0, 20, 10, 1'b1);
    idle(30);

    chk("pending_steps", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
